top: RTL and testbench
======================

Name: top

Overview:
- Small registered 4-operation arithmetic unit used as the low-power operand-isolation test vehicle.
- Two unsigned operands `a` and `b` feed four arithmetic units: multiply, add, subtract and shift-left.
- Priority selects `sel1`..`sel4` choose one unit; its result is registered onto `out`.
- Operands to every unselected unit are forced to zero (operand isolation), so idle units do not toggle.

Parameters:
- DW, 4, operand width of `a` and `b`.
- OW, 8, result width; must equal 2*DW.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- a  input  DW  unsigned operand A.
- b  input  DW  unsigned operand B.
- sel1  input  1  select multiply (highest priority).
- sel2  input  1  select add.
- sel3  input  1  select subtract.
- sel4  input  1  select shift-left (lowest priority).
- out  output  OW  registered result.

Behaviour:
- Reset: rst=1 clears `out` to 0 immediately (asynchronous) and holds it at 0 for as long as rst stays high.
- Operation decode is a fixed priority:
  - en_mul = sel1
  - en_add = ~sel1 & sel2
  - en_sub = ~sel1 & ~sel2 & sel3
  - en_shl = ~sel1 & ~sel2 & ~sel3 & sel4
  - At most one enable is high at any time.
- While rst=1, all four enables are forced low.
- Multiply: out <= a*b, unsigned, full OW bits, never truncated.
- Add: out <= zero-extend(a+b), a DW+1-bit sum.
- Subtract: out <= sign-extend(a-b), computed as DW+1-bit two's complement. Example: a<b gives a negative OW-bit value.
- Shift-left: out <= zero-extend(a) << b[1:0]. Upper bits of `b` are ignored; maximum shift is 3.
- No select high: `out` holds its previous value (register load enable is low).
- Any select that is X/Z: treated as 0.
- Latency: combinational decode and compute, then one register stage. `out` reflects the inputs sampled at the rising clk edge; one-cycle latency.
- Isolation: each unit's operand pair is ANDed with that unit's enable, so a disabled unit sees a=0, b=0. The output mux selects only the enabled unit.
- Reset mid-operation: `out` clears asynchronously. The first post-reset load occurs at the first rising edge with rst=0 and a select high.
- Reset deassertion is synchronized externally; no internal synchronizer.

Optional Feature:
- OPERAND_ISOLATION_EN defined: AND-gate operand isolation is instantiated per unit as described in Behaviour.
- OPERAND_ISOLATION_EN undefined: all units receive raw `a`/`b`, and only the output mux uses the enables.
- The functional `out` sequence is bit-identical in both builds; only internal toggle activity differs.

Decomposition:
- Package `top_pkg`:
  - DW/OW defaults.
  - Op enum: OP_NONE, OP_MUL, OP_ADD, OP_SUB, OP_SHL.
  - Function `decode_sel(sel1..sel4)` returning the op.
- Sub-module `top_operand_iso`:
  - Parameterized WIDTH.
  - Inputs `en`, `a`, `b`; outputs `a_iso`, `b_iso` (each = operand AND `en`).
  - Instantiated four times, once per unit, only under OPERAND_ISOLATION_EN.

Test Plan:
- rst=1, a=8, b=2, selects toggling through all combinations -> out stays 0x00 throughout; all unit operands remain 0 (isolation build).
- rst=0, a=8, b=2:
  - sel1=1 with any other sels -> out=0x10 next edge.
  - sel1=0, sel2=1 -> 0x0A.
  - sel1=0, sel2=0, sel3=1 -> 0x06.
  - sel1=0, sel2=0, sel3=0, sel4=1 -> 0x20.
- Subtract negative: a=2, b=8, sel3 only -> out=0xFA.
- Extremes: a=15, b=15:
  - sel1 -> 0xE1
  - sel2 -> 0x1E
  - sel4 (shift 3) -> 0x78
- Hold: after out=0x10, all sels=0 while a/b change -> out stays 0x10.
- Async reset mid-run: assert rst between clock edges while out=0x20 -> out=0x00 before the next edge; rebuild without OPERAND_ISOLATION_EN and rerun all scenarios -> identical `out` trace.

Source files
------------

// File: rtl/top_pkg.sv
// rtl/top_pkg.sv - shared widths, op encoding and select decode for the arithmetic unit
// Purpose: default operand/result widths, the operation enum and the
//          fixed-priority select decoder used by top.
// Contents: DW_DEF, OW_DEF, op_e, decode_sel().
package top_pkg;

  localparam int DW_DEF = 4;
  localparam int OW_DEF = 8;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_MUL,
    OP_ADD,
    OP_SUB,
    OP_SHL
  } op_e;

  // The if-chain makes an X/Z select fall through as if it were 0.
  function automatic op_e decode_sel(input logic sel1, input logic sel2,
                                     input logic sel3, input logic sel4);
    op_e op;
    op = OP_NONE;
    if (sel1 == 1'b1)      op = OP_MUL;
    else if (sel2 == 1'b1) op = OP_ADD;
    else if (sel3 == 1'b1) op = OP_SUB;
    else if (sel4 == 1'b1) op = OP_SHL;
    return op;
  endfunction

endpackage

// File: rtl/top_operand_iso.sv
// rtl/top_operand_iso.sv - AND-gate operand isolation for one arithmetic unit
// Purpose: forces both operands of an idle unit to zero so it does not toggle.
// Ports:
//   en            unit enable
//   a, b  [W-1:0] raw operands
//   a_iso, b_iso  operands gated by en
module top_operand_iso #(
  parameter int WIDTH = 4
) (
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] a_iso,
  output logic [WIDTH-1:0] b_iso
);

  assign a_iso = a & {WIDTH{en}};
  assign b_iso = b & {WIDTH{en}};

endmodule

// File: rtl/top.sv
// rtl/top.sv - registered 4-operation arithmetic unit with optional operand isolation
// Purpose: priority-selected multiply / add / subtract / shift-left of a and b,
//          result registered onto out with one cycle of latency.
// Build option: OPERAND_ISOLATION_EN - gate each unit's operands with its enable.
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset, clears out
//   a, b  [DW-1:0] unsigned operands
//   sel1..sel4     operation selects, sel1 highest priority
//   out   [OW-1:0] registered result, holds when no select is high
module top
  import top_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int OW = OW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          sel1,
  input  logic          sel2,
  input  logic          sel3,
  input  logic          sel4,
  output logic [OW-1:0] out
);

  op_e op;
  logic en_mul, en_add, en_sub, en_shl;

  // Reset kills every enable so no unit sees activity while held in reset.
  assign op     = rst ? OP_NONE : decode_sel(sel1, sel2, sel3, sel4);
  assign en_mul = (op == OP_MUL);
  assign en_add = (op == OP_ADD);
  assign en_sub = (op == OP_SUB);
  assign en_shl = (op == OP_SHL);

  logic [DW-1:0] mul_a, mul_b, add_a, add_b, sub_a, sub_b, shl_a, shl_b;

`ifdef OPERAND_ISOLATION_EN
  top_operand_iso #(.WIDTH(DW)) u_iso_mul (.en(en_mul), .a(a), .b(b), .a_iso(mul_a), .b_iso(mul_b));
  top_operand_iso #(.WIDTH(DW)) u_iso_add (.en(en_add), .a(a), .b(b), .a_iso(add_a), .b_iso(add_b));
  top_operand_iso #(.WIDTH(DW)) u_iso_sub (.en(en_sub), .a(a), .b(b), .a_iso(sub_a), .b_iso(sub_b));
  top_operand_iso #(.WIDTH(DW)) u_iso_shl (.en(en_shl), .a(a), .b(b), .a_iso(shl_a), .b_iso(shl_b));
`else
  assign mul_a = a;
  assign mul_b = b;
  assign add_a = a;
  assign add_b = b;
  assign sub_a = a;
  assign sub_b = b;
  assign shl_a = a;
  assign shl_b = b;
`endif

  logic [OW-1:0] mul_res, add_res, sub_res, shl_res, nxt;
  logic [DW:0]   add_sum, sub_diff;

  assign mul_res  = OW'(mul_a) * OW'(mul_b);
  assign add_sum  = {1'b0, add_a} + {1'b0, add_b};
  assign add_res  = OW'(add_sum);
  // DW+1-bit two's complement difference, sign-extended to the result width.
  assign sub_diff = {1'b0, sub_a} - {1'b0, sub_b};
  assign sub_res  = {{(OW-DW-1){sub_diff[DW]}}, sub_diff};
  // Only the low two bits of b form the shift amount.
  assign shl_res  = OW'(shl_a) << shl_b[1:0];

  always_comb begin
    nxt = out;
    case (op)
      OP_MUL:  nxt = mul_res;
      OP_ADD:  nxt = add_res;
      OP_SUB:  nxt = sub_res;
      OP_SHL:  nxt = shl_res;
      default: nxt = out;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= '0;
    end else if (op != OP_NONE) begin
      out <= nxt;
    end
  end

endmodule

// File: tb/tb_top.sv
// tb/tb_top.sv - directed self-checking bench for the registered arithmetic unit
module tb_top;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a, b;
  logic       sel1, sel2, sel3, sel4;
  logic [7:0] out;

  int checks = 0;
  int errors = 0;

  top #(.DW(4), .OW(8)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .sel1(sel1),
    .sel2(sel2),
    .sel3(sel3),
    .sel4(sel4),
    .out (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] expected);
    checks++;
    assert (out === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, out, expected);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the next rising edge.
  task automatic step(input logic [3:0] sels, input logic [3:0] va, input logic [3:0] vb);
    @(negedge clk);
    {sel1, sel2, sel3, sel4} = sels;
    a = va;
    b = vb;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a = 4'd8;
    b = 4'd2;
    {sel1, sel2, sel3, sel4} = 4'b0000;
    #1;
    chk("reset_initial", 8'h00);

    for (int i = 0; i < 16; i++) begin
      step(i[3:0], 4'd8, 4'd2);
      chk("reset_hold", 8'h00);
    end

    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      step({1'b1, i[2:0]}, 4'd8, 4'd2);
      chk("mul_8x2", 8'h10);
    end
    for (int i = 0; i < 4; i++) begin
      step({2'b01, i[1:0]}, 4'd8, 4'd2);
      chk("add_8p2", 8'h0A);
    end
    for (int i = 0; i < 2; i++) begin
      step({3'b001, i[0]}, 4'd8, 4'd2);
      chk("sub_8m2", 8'h06);
    end
    step(4'b0001, 4'd8, 4'd2);
    chk("shl_8s2", 8'h20);

    // Asynchronous reset between edges while out=0x20.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_reset", 8'h00);
    step(4'b0001, 4'd8, 4'd2);
    chk("reset_held_sel", 8'h00);
    @(negedge clk);
    rst = 1'b0;
    step(4'b0001, 4'd8, 4'd2);
    chk("post_reset_shl", 8'h20);

    step(4'b0010, 4'd2, 4'd8);
    chk("sub_negative", 8'hFA);

    step(4'b1000, 4'd15, 4'd15);
    chk("mul_max", 8'hE1);
    step(4'b0100, 4'd15, 4'd15);
    chk("add_max", 8'h1E);
    step(4'b0001, 4'd15, 4'd15);
    chk("shl_max", 8'h78);
    step(4'b0010, 4'd15, 4'd15);
    chk("sub_zero", 8'h00);
    step(4'b0001, 4'd3, 4'd13);
    chk("shl_ignore_upper_b", 8'h06);

    step(4'b1000, 4'd8, 4'd2);
    chk("hold_setup", 8'h10);
    step(4'b0000, 4'd15, 4'd15);
    chk("hold_1", 8'h10);
    step(4'b0000, 4'd1, 4'd7);
    chk("hold_2", 8'h10);
    step(4'b0000, 4'd0, 4'd0);
    chk("hold_3", 8'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
